// File: rtl/sys_ctrl.sv
// Command-frame controller between the UART byte link and the register file.
// Decodes 0xAA write and 0xBB read frames; read data goes back out as one TX byte.
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  TX_Busy,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_TX_SEND
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic                  r_tx_vld;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_tx_data;

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_tx_vld;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_tx_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_next;
      r_wr_en   <= w_wr_en;
      r_rd_en   <= w_rd_en;
      r_tx_vld  <= w_tx_vld;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_tx_data <= w_tx_data;
    end
  end

  // RdData_Valid is ignored in RD_ISSUE so a stale level cannot capture early
  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_tx_vld  = 1'b0;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_tx_data = r_tx_data;
    unique case (r_state)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR) w_next = S_WR_ADDR;
          else if (RX_P_DATA == CMD_RD) w_next = S_RD_ADDR;
        end
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          w_addr = RX_P_DATA[ADDR_WIDTH-1:0];
          w_next = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          w_wdata = RX_P_DATA;
          w_wr_en = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          w_addr  = RX_P_DATA[ADDR_WIDTH-1:0];
          w_rd_en = 1'b1;
          w_next  = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (RdData_Valid) begin
          w_tx_data = RdData;
          w_next    = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        if (!TX_Busy) begin
          w_tx_vld = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign WrEn      = r_wr_en;
  assign RdEn      = r_rd_en;
  assign TX_D_VLD  = r_tx_vld;
  assign Address   = r_addr;
  assign WrData    = r_wdata;
  assign TX_P_DATA = r_tx_data;

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: frame-level reference model, register-file
// model with configurable read latency, and a decoupled output monitor.
module tb_sys_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RdData = 8'h00;
  logic       RdData_Valid = 1'b0;
  logic       TX_Busy = 1'b0;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;

  sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .TX_Busy(TX_Busy),
    .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] d; int cyc; } tx_t;

  wr_t        wr_q[$];
  logic [3:0] rd_q[$];
  tx_t        tx_q[$];

  logic [7:0] init_mem [16];
  logic [7:0] ref_mem  [16];
  logic [7:0] mem      [16];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rf_lat = 0;
  bit sticky = 1'b0;

  logic       pend = 1'b0;
  int         pcnt = 0;
  logic [3:0] pa   = 4'h0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Register file model: RdData appears rf_lat cycles after the RdEn edge.
  always @(posedge CLK) begin
    if (cyc == 0) foreach (mem[i]) mem[i] <= init_mem[i];
    if (!sticky) RdData_Valid <= 1'b0;
    if (RdEn) begin
      if (rf_lat == 0) begin
        RdData       <= mem[Address];
        RdData_Valid <= 1'b1;
      end else begin
        pend <= 1'b1;
        pcnt <= rf_lat;
        pa   <= Address;
      end
    end else if (pend) begin
      if (pcnt == 1) begin
        RdData       <= mem[pa];
        RdData_Valid <= 1'b1;
        pend         <= 1'b0;
      end else begin
        pcnt <= pcnt - 1;
      end
    end
    if (WrEn && cyc != 0) mem[Address] <= WrData;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    wr_t e;
    tx_t t;
    logic [3:0] ra;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("reset_outputs",
            {WrEn, RdEn, TX_D_VLD, Address, WrData, TX_P_DATA}, 0);
      end else begin
        if (WrEn || RdEn) chk("strobe_overlap", WrEn && RdEn, 0);
        if (WrEn) begin
          chk("wren_expected", wr_q.size() > 0, 1);
          if (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            chk("wr_addr", Address, e.a);
            chk("wr_data", WrData, e.d);
          end
        end
        if (RdEn) begin
          chk("rden_expected", rd_q.size() > 0, 1);
          if (rd_q.size() > 0) begin
            ra = rd_q.pop_front();
            chk("rd_addr", Address, ra);
          end
        end
        if (TX_D_VLD) begin
          chk("tx_expected", tx_q.size() > 0, 1);
          if (tx_q.size() > 0) begin
            t = tx_q.pop_front();
            chk("tx_data", TX_P_DATA, t.d);
            chk("tx_cycle", cyc, t.cyc);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    RX_D_VLD  = 1'b1;
    RX_P_DATA = b;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_q.push_back('{a: a, d: d});
    ref_mem[a] = d;
    send_byte(8'hAA);
    send_byte({4'($urandom), a});
    send_byte(d);
  endtask

  task automatic wait_tx();
    int b = 0;
    while (tx_q.size() > 0 && b < 200) begin
      @(posedge CLK);
      #1;
      b++;
    end
    chk("tx_pending_timeout", tx_q.size(), 0);
  endtask

  // busy>0 holds TX_Busy high for that many cycles after the address strobe;
  // drop injects 0xAA bytes while the read is still in flight.
  task automatic do_read(input logic [3:0] a, input int lat,
                         input int busy, input bit drop);
    int n0;
    logic [7:0] exp_d;
    rf_lat = lat;
    exp_d  = ref_mem[a];
    rd_q.push_back(a);
    if (busy > 0) TX_Busy = 1'b1;
    send_byte(8'hBB);
    send_byte({4'($urandom), a});
    n0 = cyc;
    tx_q.push_back('{d: exp_d, cyc: (busy > 0) ? n0 + busy + 1 : n0 + 3 + lat});
    if (busy > 0) begin
      for (int i = 0; i < busy; i++) begin
        RX_D_VLD  = drop && (i == 1 || i == 4);
        RX_P_DATA = 8'hAA;
        @(posedge CLK);
        #1;
      end
      RX_D_VLD = 1'b0;
      chk("tx_hold_during_busy", TX_P_DATA, exp_d);
      TX_Busy = 1'b0;
    end
    wait_tx();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] bad;
    int r;
    foreach (init_mem[i]) init_mem[i] = 8'($urandom);
    init_mem[2] = 8'h81;
    foreach (ref_mem[i]) ref_mem[i] = init_mem[i];

    idle(3);
    RST = 1'b1;
    idle(1);
    chk("post_reset_outputs",
        {WrEn, RdEn, TX_D_VLD, Address, WrData, TX_P_DATA}, 0);

    do_write(4'h5, 8'h3C);
    idle(2);
    do_read(4'h2, 0, 0, 1'b0);
    do_read(4'h2, 0, 10, 1'b1);

    send_byte(8'h55);
    idle(2);
    do_write(4'h1, 8'h7F);
    idle(2);

    send_byte(8'hAA);
    send_byte(8'h03);
    RST = 1'b0;
    idle(2);
    RST = 1'b1;
    send_byte(8'h44);
    idle(4);
    do_write(4'h3, 8'h44);

    do_write(4'h4, 8'h10);
    do_read(4'h4, 0, 0, 1'b0);
    do_read(4'h3, 2, 0, 1'b0);

    do_write(4'h6, 8'h11);
    do_write(4'h7, 8'hEE);
    sticky = 1'b1;
    do_read(4'h6, 0, 0, 1'b0);
    do_read(4'h7, 0, 0, 1'b0);
    sticky = 1'b0;
    idle(2);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        do_write(4'($urandom), 8'($urandom));
      end else if (r < 8) begin
        do_read(4'($urandom), $urandom_range(0, 3), 0, 1'b0);
      end else begin
        bad = 8'($urandom);
        if (bad == 8'hAA || bad == 8'hBB) bad = 8'h00;
        send_byte(bad);
      end
    end

    idle(6);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
